// File: rtl/fsm_game_multi.sv
// Maze game controller: N keys in any order, per-life step budget, internal exit countdown.
// Latency: every input is sampled on a rising edge and its effect is visible right after that edge (1 cycle).
// Backpressure: none. Inputs are levels/pulses sampled every cycle, and outputs are always valid.
//
// Ports: clk_50MHz_i, rst_sync_ha_i (synchronous, active-high); start_i, step_i, in_key_pos_i[NUM_KEYS],
// in_exit_pos_i -> keys_held_o, steps_left_o, lives_o, enable_count_last_o, state_o, red_o/green_o/blue_o.
// Optional macro FSM_GAME_BLINK_EN: the RGB LED blinks 111/000 every BLINK_HALF cycles while in EXIT.
module fsm_game_multi #(
    parameter int NUM_KEYS    = 4,
    parameter int MAX_STEPS   = 200,
    parameter int STEP_W      = 8,
    parameter int LIVES       = 3,
    parameter int EXIT_CYCLES = 750_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic                clk_50MHz_i,
    input  logic                rst_sync_ha_i,
    input  logic                start_i,
    input  logic                step_i,
    input  logic [NUM_KEYS-1:0] in_key_pos_i,
    input  logic                in_exit_pos_i,
    output logic [NUM_KEYS-1:0] keys_held_o,
    output logic [STEP_W-1:0]   steps_left_o,
    output logic [2:0]          lives_o,
    output logic                enable_count_last_o,
    output logic [2:0]          state_o,
    output logic                red_o,
    output logic                green_o,
    output logic                blue_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAME = 3'd1,
        EXIT = 3'd2,
        WON  = 3'd3,
        LOST = 3'd4
    } state_t;

    localparam logic [STEP_W-1:0] STEPS_INIT = STEP_W'(MAX_STEPS);
    localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
    localparam logic [31:0]       EXIT_LAST  = 32'(EXIT_CYCLES - 1);

    state_t              state, state_nxt;
    logic [NUM_KEYS-1:0] keys, keys_nxt;
    logic [STEP_W-1:0]   steps, steps_nxt;
    logic [2:0]          lives, lives_nxt;
    logic [31:0]         exit_cnt, exit_cnt_nxt;
    logic [NUM_KEYS-1:0] keys_merged;

    // A key picked up in the same cycle as reaching the exit still counts.
    assign keys_merged = keys | in_key_pos_i;

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_ha_i) begin
            state    <= IDLE;
            keys     <= '0;
            steps    <= STEPS_INIT;
            lives    <= LIVES_INIT;
            exit_cnt <= '0;
        end else begin
            state    <= state_nxt;
            keys     <= keys_nxt;
            steps    <= steps_nxt;
            lives    <= lives_nxt;
            exit_cnt <= exit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        keys_nxt     = keys;
        steps_nxt    = steps;
        lives_nxt    = lives;
        exit_cnt_nxt = exit_cnt;
        case (state)
            IDLE, WON, LOST: begin
                if (start_i) begin
                    state_nxt = GAME;
                    keys_nxt  = '0;
                    steps_nxt = STEPS_INIT;
                    lives_nxt = LIVES_INIT;
                end
            end
            GAME: begin
                keys_nxt = keys_merged;
                if (in_exit_pos_i && (&keys_merged)) begin
                    // An accepted exit wins over a simultaneous step.
                    state_nxt    = EXIT;
                    exit_cnt_nxt = '0;
                end else if (step_i) begin
                    if (steps > STEP_W'(1)) begin
                        steps_nxt = steps - STEP_W'(1);
                    end else if (lives > 3'd1) begin
                        lives_nxt = lives - 3'd1;
                        steps_nxt = STEPS_INIT;
                    end else begin
                        steps_nxt = '0;
                        lives_nxt = '0;
                        state_nxt = LOST;
                    end
                end
            end
            EXIT: begin
                if (exit_cnt == EXIT_LAST) begin
                    state_nxt = WON;
                end else begin
                    exit_cnt_nxt = exit_cnt + 32'd1;
                end
            end
            default: state_nxt = IDLE;   // encodings 5..7
        endcase
    end

`ifdef FSM_GAME_BLINK_EN
    // Phase divider instead of dividing exit_cnt: blink_off toggles every BLINK_HALF cycles in EXIT.
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
    logic [31:0] blink_cnt;
    logic        blink_off;

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_ha_i || state != EXIT) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 32'd1;
        end
    end
`endif

    logic [2:0] rgb;

    always_comb begin
        rgb                 = 3'b001;
        enable_count_last_o = 1'b0;
        case (state)
            IDLE: rgb = 3'b001;
            GAME: rgb = 3'b111;
            EXIT: begin
                enable_count_last_o = 1'b1;
`ifdef FSM_GAME_BLINK_EN
                rgb = blink_off ? 3'b000 : 3'b111;
`else
                rgb = 3'b111;
`endif
            end
            WON:     rgb = 3'b010;
            LOST:    rgb = 3'b100;
            default: rgb = 3'b001;
        endcase
    end

    assign {red_o, green_o, blue_o} = rgb;
    assign keys_held_o  = keys;
    assign steps_left_o = steps;
    assign lives_o      = lives;
    assign state_o      = state;

endmodule
